// File: rtl/cache_tag_tracker.sv
// cache_tag_tracker
//   Tag/state model of a set-associative, write-allocate data cache driven by
//   a trace of (command, address) pairs. Each address is split into
//   tag/index/byte_select. Per-way valid, dirty and LRU-age state is kept for
//   every set, along with read/write/hit/miss statistics counters.
//
// Ports
//   clk, rst         clock and synchronous active-high reset
//   cmd_valid        one command consumed per cycle while high
//   cmd              command code (0 read, 1 write, 2 ifetch, 3 invalidate,
//                    4 snoop read, 8 clear, 9 print, others ignored)
//   read_address     command address
//   tag/index/byte_select  combinational address fields
//   resp_valid/resp_hit    registered lookup response, one cycle latency
//   cache_read/cache_write/cache_hit/cache_miss  statistics counters
module cache_tag_tracker #(
  parameter int ADDR_BITS   = 32,
  parameter int OFFSET_BITS = 6,
  parameter int INDEX_BITS  = 4,
  parameter int WAYS        = 4,
  parameter int TAG_BITS    = ADDR_BITS - INDEX_BITS - OFFSET_BITS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  input  logic [3:0]             cmd,
  input  logic [ADDR_BITS-1:0]   read_address,
  output logic [TAG_BITS-1:0]    tag,
  output logic [INDEX_BITS-1:0]  index,
  output logic [OFFSET_BITS-1:0] byte_select,
  output logic                   resp_valid,
  output logic                   resp_hit,
  output logic [31:0]            cache_read,
  output logic [31:0]            cache_write,
  output logic [31:0]            cache_hit,
  output logic [31:0]            cache_miss
);

  localparam int SETS     = 1 << INDEX_BITS;
  localparam int AGE_BITS = $clog2(WAYS);

  logic [TAG_BITS-1:0] tag_q   [SETS][WAYS];
  logic [TAG_BITS-1:0] tag_d   [SETS][WAYS];
  logic [AGE_BITS-1:0] age_q   [SETS][WAYS];
  logic [AGE_BITS-1:0] age_d   [SETS][WAYS];
  logic [WAYS-1:0]     valid_q [SETS];
  logic [WAYS-1:0]     valid_d [SETS];
  logic [WAYS-1:0]     dirty_q [SETS];
  logic [WAYS-1:0]     dirty_d [SETS];

  logic        resp_valid_q, resp_valid_d;
  logic        resp_hit_q, resp_hit_d;
  logic [31:0] cache_read_q, cache_read_d;
  logic [31:0] cache_write_q, cache_write_d;
  logic [31:0] cache_hit_q, cache_hit_d;
  logic [31:0] cache_miss_q, cache_miss_d;

  logic                hit;
  logic [AGE_BITS-1:0] hit_way;
  logic                victim_found;
  logic [AGE_BITS-1:0] victim_way;
  logic [AGE_BITS-1:0] acc_way;
  logic [AGE_BITS-1:0] old_age;

  assign tag         = read_address[ADDR_BITS-1 : INDEX_BITS+OFFSET_BITS];
  assign index       = read_address[INDEX_BITS+OFFSET_BITS-1 : OFFSET_BITS];
  assign byte_select = read_address[OFFSET_BITS-1:0];

  assign resp_valid  = resp_valid_q;
  assign resp_hit    = resp_hit_q;
  assign cache_read  = cache_read_q;
  assign cache_write = cache_write_q;
  assign cache_hit   = cache_hit_q;
  assign cache_miss  = cache_miss_q;

  // Tag lookup and victim choice for the addressed set. Victim is the lowest
  // invalid way; when the set is full it is the oldest way (age WAYS-1).
  always_comb begin
    hit          = 1'b0;
    hit_way      = '0;
    victim_found = 1'b0;
    victim_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[index][w] && (tag_q[index][w] == tag)) begin
        hit     = 1'b1;
        hit_way = AGE_BITS'(w);
      end
      if (!victim_found && !valid_q[index][w]) begin
        victim_found = 1'b1;
        victim_way   = AGE_BITS'(w);
      end
    end
    if (!victim_found) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age_q[index][w] == AGE_BITS'(WAYS - 1)) begin
          victim_way = AGE_BITS'(w);
        end
      end
    end
    acc_way = hit ? hit_way : victim_way;
    old_age = age_q[index][acc_way];
  end

  // Next-state for the cache arrays, counters and response.
  always_comb begin
    tag_d         = tag_q;
    age_d         = age_q;
    valid_d       = valid_q;
    dirty_d       = dirty_q;
    cache_read_d  = cache_read_q;
    cache_write_d = cache_write_q;
    cache_hit_d   = cache_hit_q;
    cache_miss_d  = cache_miss_q;
    resp_valid_d  = 1'b0;
    resp_hit_d    = 1'b0;
    if (cmd_valid) begin
      case (cmd)
        4'd0, 4'd1, 4'd2: begin
          resp_valid_d = 1'b1;
          resp_hit_d   = hit;
          if (cmd == 4'd1) cache_write_d = cache_write_q + 32'd1;
          else             cache_read_d  = cache_read_q + 32'd1;
          if (hit) begin
            cache_hit_d = cache_hit_q + 32'd1;
          end else begin
            cache_miss_d                 = cache_miss_q + 32'd1;
            tag_d[index][victim_way]     = tag;
            valid_d[index][victim_way]   = 1'b1;
            dirty_d[index][victim_way]   = 1'b0;
          end
          if (cmd == 4'd1) dirty_d[index][acc_way] = 1'b1;
          // Promote to MRU: only ways younger than the accessed one age,
          // which keeps the ages a permutation of 0..WAYS-1.
          for (int w = 0; w < WAYS; w++) begin
            if (AGE_BITS'(w) == acc_way)
              age_d[index][w] = '0;
            else if (age_q[index][w] < old_age)
              age_d[index][w] = age_q[index][w] + AGE_BITS'(1);
          end
        end
        4'd3: begin
          if (hit) begin
            valid_d[index][hit_way] = 1'b0;
            dirty_d[index][hit_way] = 1'b0;
          end
        end
        4'd4: begin
          if (hit) dirty_d[index][hit_way] = 1'b0;
        end
        4'd8: begin
          for (int s = 0; s < SETS; s++) begin
            valid_d[s] = '0;
            dirty_d[s] = '0;
            for (int w = 0; w < WAYS; w++) age_d[s][w] = AGE_BITS'(w);
          end
          cache_read_d  = '0;
          cache_write_d = '0;
          cache_hit_d   = '0;
          cache_miss_d  = '0;
        end
        default: ;
      endcase
    end
  end

  // State registers; reset takes priority over any command on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          age_q[s][w] <= AGE_BITS'(w);
          tag_q[s][w] <= '0;
        end
      end
      resp_valid_q  <= 1'b0;
      resp_hit_q    <= 1'b0;
      cache_read_q  <= '0;
      cache_write_q <= '0;
      cache_hit_q   <= '0;
      cache_miss_q  <= '0;
    end else begin
      tag_q         <= tag_d;
      age_q         <= age_d;
      valid_q       <= valid_d;
      dirty_q       <= dirty_d;
      resp_valid_q  <= resp_valid_d;
      resp_hit_q    <= resp_hit_d;
      cache_read_q  <= cache_read_d;
      cache_write_q <= cache_write_d;
      cache_hit_q   <= cache_hit_d;
      cache_miss_q  <= cache_miss_d;
    end
  end

endmodule

// File: tb/tb_cache_tag_tracker.sv
// Directed testbench for cache_tag_tracker. Each step drives one command,
// lets one rising edge consume it, then checks registered outputs 1ns later.
module tb_cache_tag_tracker;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [3:0]  cmd = 4'd0;
  logic [31:0] read_address = 32'd0;
  logic [21:0] tag;
  logic [3:0]  index;
  logic [5:0]  byte_select;
  logic        resp_valid;
  logic        resp_hit;
  logic [31:0] cache_read;
  logic [31:0] cache_write;
  logic [31:0] cache_hit;
  logic [31:0] cache_miss;

  int assert_count = 0;
  int fail_count   = 0;

  cache_tag_tracker dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd          (cmd),
    .read_address (read_address),
    .tag          (tag),
    .index        (index),
    .byte_select  (byte_select),
    .resp_valid   (resp_valid),
    .resp_hit     (resp_hit),
    .cache_read   (cache_read),
    .cache_write  (cache_write),
    .cache_hit    (cache_hit),
    .cache_miss   (cache_miss)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] observed,
                             input logic [31:0] expected);
    assert_count++;
    assert (observed === expected)
    else begin
      fail_count++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", name, observed, expected);
    end
  endtask

  // One command through one rising edge; outputs are then stable for checks.
  task automatic applyStimulus(input logic [3:0] c, input logic [31:0] a);
    cmd_valid    = 1'b1;
    cmd          = c;
    read_address = a;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic resetDut();
    rst       = 1'b1;
    cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic checkCounters(input string name, input int rd, input int wr,
                               input int ht, input int ms);
    checkOutput({name, "_read"},  cache_read,  rd);
    checkOutput({name, "_write"}, cache_write, wr);
    checkOutput({name, "_hit"},   cache_hit,   ht);
    checkOutput({name, "_miss"},  cache_miss,  ms);
  endtask

  initial begin
    // Reset state
    resetDut();
    resetDut();
    checkCounters("reset", 0, 0, 0, 0);
    checkOutput("reset_resp_valid", resp_valid, 0);
    checkOutput("reset_resp_hit", resp_hit, 0);

    // Combinational field split
    read_address = 32'h1234_5678;
    #1;
    checkOutput("split_tag", tag, 32'h48D15);
    checkOutput("split_index", index, 32'd9);
    checkOutput("split_byte", byte_select, 32'h38);

    // Cold miss then hit
    applyStimulus(4'd0, 32'h40);
    checkOutput("cold_resp_valid", resp_valid, 1);
    checkOutput("cold_resp_hit", resp_hit, 0);
    applyStimulus(4'd0, 32'h40);
    checkOutput("warm_resp_valid", resp_valid, 1);
    checkOutput("warm_resp_hit", resp_hit, 1);
    checkCounters("coldwarm", 2, 0, 1, 1);

    // LRU eviction in set 0
    resetDut();
    applyStimulus(4'd0, 32'h000);
    applyStimulus(4'd0, 32'h400);
    applyStimulus(4'd0, 32'h800);
    applyStimulus(4'd0, 32'hC00);
    checkCounters("fill", 4, 0, 0, 4);
    applyStimulus(4'd0, 32'h1000);
    checkOutput("evict1_hit", resp_hit, 0);
    applyStimulus(4'd0, 32'h000);
    checkOutput("evict0_hit", resp_hit, 0);
    applyStimulus(4'd0, 32'h800);
    checkOutput("lru_keep_hit", resp_hit, 1);
    checkCounters("lru", 7, 0, 1, 6);
    applyStimulus(4'd0, 32'h400);
    checkOutput("lru_evicted_hit", resp_hit, 0);
    applyStimulus(4'd0, 32'hC00);
    checkOutput("lru_c00_hit", resp_hit, 0);

    // Write / snoop / invalidate
    resetDut();
    applyStimulus(4'd1, 32'h80);
    checkOutput("wr_resp_hit", resp_hit, 0);
    checkCounters("wr", 0, 1, 0, 1);
    applyStimulus(4'd4, 32'h80);
    checkOutput("snoop_resp_valid", resp_valid, 0);
    checkCounters("snoop", 0, 1, 0, 1);
    applyStimulus(4'd3, 32'h80);
    checkOutput("inval_resp_valid", resp_valid, 0);
    checkCounters("inval", 0, 1, 0, 1);
    applyStimulus(4'd0, 32'h80);
    checkOutput("after_inval_hit", resp_hit, 0);
    checkCounters("after_inval", 1, 1, 0, 2);
    checkOutput("invariant", cache_hit + cache_miss, cache_read + cache_write);

    // Clear mid-stream
    applyStimulus(4'd0, 32'h80);
    checkOutput("pre_clear_hit", resp_hit, 1);
    applyStimulus(4'd8, 32'h0);
    checkCounters("clear", 0, 0, 0, 0);
    checkOutput("clear_resp_valid", resp_valid, 0);
    applyStimulus(4'd0, 32'h80);
    checkOutput("post_clear_hit", resp_hit, 0);
    checkCounters("post_clear", 1, 0, 0, 1);

    // Reset together with a read: the read is dropped
    rst          = 1'b1;
    cmd_valid    = 1'b1;
    cmd          = 4'd0;
    read_address = 32'h80;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    cmd_valid = 1'b0;
    checkCounters("rst_cmd", 0, 0, 0, 0);
    checkOutput("rst_cmd_resp_valid", resp_valid, 0);
    applyStimulus(4'd0, 32'h80);
    checkOutput("post_rst_hit", resp_hit, 0);

    // Ignored codes interleaved with reads
    resetDut();
    applyStimulus(4'd0, 32'h40);
    applyStimulus(4'd9, 32'h40);
    checkOutput("print_resp_valid", resp_valid, 0);
    checkCounters("print", 1, 0, 0, 1);
    applyStimulus(4'd0, 32'h40);
    checkOutput("ign_read_hit", resp_hit, 1);
    applyStimulus(4'd5, 32'h40);
    checkOutput("code5_resp_valid", resp_valid, 0);
    checkCounters("code5", 2, 0, 1, 1);
    applyStimulus(4'd2, 32'h40);
    checkOutput("ifetch_hit", resp_hit, 1);
    checkCounters("ifetch", 3, 0, 2, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/cache_tag_tracker.md
Name: cache_tag_tracker

Overview:
- Synchronous tag/state model of a set-associative, write-allocate data cache driven by a trace of (command, address) pairs.
- Splits each 32-bit address into tag/index/offset fields.
- Tracks per-way valid/dirty/LRU state and maintains read, write, hit and miss statistics counters.
- Sits between the trace-file reader (upstream) and the statistics reporting logic (downstream).

Parameters:
- ADDR_BITS, 32, address width.
- OFFSET_BITS, 6, byte-select field width (64-byte lines).
- INDEX_BITS, 4, set-index width (16 sets).
- WAYS, 4, associativity; must be a power of 2, at least 2.
- TAG_BITS, ADDR_BITS-INDEX_BITS-OFFSET_BITS, derived; never overridden.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command strobe; one command consumed per cycle while high.
- cmd  in  4  command code.
- read_address  in  ADDR_BITS  command address.
- tag  out  TAG_BITS  read_address[ADDR_BITS-1 : INDEX_BITS+OFFSET_BITS], combinational.
- index  out  INDEX_BITS  read_address[INDEX_BITS+OFFSET_BITS-1 : OFFSET_BITS], combinational.
- byte_select  out  OFFSET_BITS  read_address[OFFSET_BITS-1:0], combinational.
- resp_valid  out  1  registered; pulses one cycle after a cmd 0/1/2 is accepted.
- resp_hit  out  1  registered; lookup result qualified by resp_valid.
- cache_read  out  32  count of cmd 0 and cmd 2.
- cache_write  out  32  count of cmd 1.
- cache_hit  out  32  count of lookup hits.
- cache_miss  out  32  count of lookup misses.

Behaviour:
- Reset (rst=1 at clk edge):
  - All valid and dirty bits cleared; LRU age of way w in every set set to w.
  - All counters, resp_valid and resp_hit set to 0.
  - rst has priority over cmd_valid.
- Lookup: hit when some way in set[index] is valid with a matching tag. Tags are unique per set by construction.
- Command decode, acting on the edge where cmd_valid=1:
  - 0 data read, 2 instruction fetch:
    - cache_read+1.
    - On hit: cache_hit+1 and hit way made MRU.
    - On miss: cache_miss+1 and allocate.
  - 1 data write:
    - cache_write+1; hit/miss counting and allocation as for reads.
    - Accessed way marked dirty and made MRU.
  - 3 invalidate: matching way gets valid=0 and dirty=0; LRU and counters unchanged; no effect on a miss.
  - 4 snoop read: matching dirty way gets dirty=0; nothing else changes.
  - 8 clear: identical effect to reset.
  - 9 print: no state change.
  - Any other code: ignored, no state change.
- Allocation: victim is the lowest-index invalid way, otherwise the way with age WAYS-1. The victim is loaded with the new tag, valid=1, dirty=(cmd==1), and made MRU.
- MRU update: the accessed way's age becomes 0. Every other way in that set whose age was lower than the accessed way's old age increments by 1. Ages always form a permutation of 0..WAYS-1.
- Response timing: resp_valid/resp_hit are registered with 1-cycle latency. resp_valid is 0 in any cycle following a non-lookup command or cmd_valid=0.
- Counters: update on the same edge the command is accepted; visible the next cycle. Wrap modulo 2^32.
- Back-to-back commands to the same set each cycle see the state written by the previous edge; no forwarding hazards are permitted.
- Invariant: cache_hit + cache_miss == cache_read + cache_write at all times.

Test Plan:
- Field split: read_address=0x12345678 -> tag=0x48D15, index=9, byte_select=0x38, same cycle.
- Cold miss then hit: cmd 0 @0x40, then cmd 0 @0x40.
  - Required response: resp_hit=0 then 1.
  - Counters afterwards: cache_read=2, cache_hit=1, cache_miss=1.
- LRU eviction: cmd 0 to 0x000, 0x400, 0x800, 0xC00, 0x1000 (all index 0), then 0x000, then 0x800.
  - First six accesses: misses.
  - Final access to 0x800: hit.
  - Final counters: cache_miss=6, cache_hit=1.
- Write/snoop/invalidate: cmd 1 @0x80, then cmd 4 @0x80, then cmd 3 @0x80, then cmd 0 @0x80.
  - cmd 1 is a miss; cache_write=1.
  - cmd 4 and cmd 3 do not change the counters.
  - cmd 0 afterwards is a miss; cache_miss=2.
- Clear and reset mid-stream: after the traffic above, cmd 8 -> all counters 0 next cycle and a prior hit address now misses. Asserting rst together with cmd_valid=1, cmd=0 -> command ignored and counters 0.
- Ignored codes: cmd 9 and cmd 5 interleaved with reads -> no counter change; resp_valid=0 on the following cycle.
